sync_mq_cell_fifo: RTL
======================

Name: sync_mq_cell_fifo

Overview:
Multi-queue synchronous cell FIFO. NCH independent cell queues share one simple-dual-port RAM, statically partitioned into one region per channel. Writers and readers choose a channel and a word offset inside the cell. Cells are committed and released atomically at end-of-cell. The block is the multi-channel successor of the single-queue cell FIFO and is used in front of per-port schedulers.

Parameters:
- VENDOR, "ALTERA": passed to the RAM.
- RAM_TYPE, "MRAM": RAM style.
- DWIDTH, 8: data width.
- CWIDTH, 2: in-cell word address width; a cell holds 2**CWIDTH words.
- QWIDTH, 2: cell index width; each channel holds 2**QWIDTH cells.
- CHW, 2: channel select width; NCH = 2**CHW.
- ALFULL_TH, 1: almost-full threshold, in free cells.
- ALEMPTY_TH, 1: almost-empty threshold, in stored cells.
- REG_OUT, 0: 1 adds an output register stage to the RAM.

Ports:
- i_clk_sys  in  1  system clock
- i_rst_n  in  1  reset; asynchronous, active-low
- i_wen  in  1  write word
- i_weoc  in  1  commit the current write cell; qualified by i_wen
- i_wch  in  CHW  write channel
- i_waddr  in  CWIDTH  word offset in the write cell
- i_wdata  in  DWIDTH  write data
- i_ren  in  1  read word
- i_reoc  in  1  release the current read cell; qualified by i_ren
- i_rch  in  CHW  read channel
- i_raddr  in  CWIDTH  word offset in the read cell
- o_rdata  out  DWIDTH  read data
- o_rvalid  out  1  o_rdata valid
- o_rch  out  CHW  channel of o_rdata
- o_full  out  NCH  per-channel full
- o_alfull  out  NCH  per-channel almost full
- o_empty  out  NCH  per-channel empty
- o_alempty  out  NCH  per-channel almost empty
- o_overflow  out  NCH  one-cycle pulse: write rejected
- o_underflow  out  NCH  one-cycle pulse: read rejected
- o_cell_cnt  out  NCH*(QWIDTH+1)  flattened committed-cell counts; channel c occupies bits [c*(QWIDTH+1) +: QWIDTH+1]

Behaviour:
- Per-channel state: wptr and rptr, each QWIDTH bits (wrap modulo 2**QWIDTH), and cnt, QWIDTH+1 bits, range 0..2**QWIDTH.
- RAM address = {ch, ptr, offset}. RAM AWIDTH = CHW+QWIDTH+CWIDTH.
- Write accepted when i_wen && !o_full[i_wch]:
  - RAM write at {i_wch, wptr[i_wch], i_waddr}.
  - If i_weoc is also set, wptr[i_wch] increments.
- Rejected write (full): no RAM write, no pointer change, o_overflow[i_wch]=1 on the next cycle for one cycle.
- Read accepted when i_ren && !o_empty[i_rch]:
  - RAM read at {i_rch, rptr[i_rch], i_raddr}.
  - If i_reoc is also set, rptr[i_rch] increments.
- Rejected read (empty): no RAM read, o_underflow[i_rch] pulses, o_rvalid stays 0.
- Cell count update per channel: +1 on an accepted write-eoc, -1 on an accepted read-eoc. Both in the same cycle on the same channel leave cnt unchanged.
- Acceptance uses the pre-cycle flags. A full channel rejects a write even while a same-cycle read-eoc frees a cell.
- Uncommitted words (no eoc yet) are invisible to the reader. Rewriting an offset before eoc overwrites it.
- Flags are combinational decodes of the cnt registers:
  - full: cnt == 2**QWIDTH
  - empty: cnt == 0
  - alfull: cnt >= 2**QWIDTH - ALFULL_TH
  - alempty: cnt <= ALEMPTY_TH
- Read latency: o_rvalid/o_rdata/o_rch appear 1 cycle after an accepted read when REG_OUT=0, 2 cycles when REG_OUT=1.
- Back-to-back accepted reads produce back-to-back o_rvalid.
- Reset values: all pointers and counts 0; o_empty and o_alempty all 1; o_full 0; o_alfull 0 unless the threshold decode is true at cnt=0; o_overflow, o_underflow, o_rvalid, o_rch and o_rdata 0.
- Reset mid-operation discards every queue, including partially written cells, and cancels in-flight read data (o_rvalid=0). RAM contents are not cleared.
- Simultaneous write and read to the same channel are independent because they always address different cells. A read of a committed cell never aliases the open write cell.

Decomposition:
- Package sync_mq_cell_fifo_pkg holds the derived constants NCH, CELLS = 2**QWIDTH, CNTW = QWIDTH+1 and AWIDTH, plus the function that computes the flattened cnt slice index.
- Sub-module sync_mq_cell_ctrl: one channel's wptr/rptr/cnt, its flags and its pulses. Instantiated NCH times in a generate loop.
- The top adds the channel muxes, the RAM address build, the read-valid/channel pipeline and the existing Simple_dual_port_RAM.

Test Plan:
- Reset, then idle -> o_empty=4'hF, o_full=0, o_cell_cnt=0, no o_rvalid.
- Write one cell 0xA0..0xA3 at ch2 offsets 0..3 with eoc on offset 3, then read ch2 offsets 3,2,1,0 with eoc on the last read -> o_rdata A3,A2,A1,A0 one cycle after each read, o_rch=2, ch2 count 1 then 0.
- Fill ch1 with 4 cells, then write a 5th -> o_full[1]=1, o_alfull[1] asserted at count 3, o_overflow[1] pulses once, ch1 data unchanged. Other channels remain empty.
- Read ch0 while empty -> o_underflow[0] pulses, o_rvalid=0, all counts unchanged.
- Hold ch3 at 2 cells, then issue write-eoc and read-eoc on ch3 in the same cycle -> count stays 2. Repeat for 10 cells total -> pointers wrap and data order is preserved.
- Write 2 words into ch0 without eoc, then assert reset -> o_empty[0]=1. A later full cell written to ch0 reads back correctly. Repeat the data scenarios with REG_OUT=1 -> latency is 2.

Source files
------------

// File: rtl/sync_mq_cell_fifo_pkg.sv
// Shared sizing helpers for the multi-queue cell FIFO.
package sync_mq_cell_fifo_pkg;

    function automatic int unsigned nch(input int unsigned chw);
        return 1 << chw;
    endfunction

    function automatic int unsigned cells(input int unsigned qwidth);
        return 1 << qwidth;
    endfunction

    function automatic int unsigned cntw(input int unsigned qwidth);
        return qwidth + 1;
    endfunction

    function automatic int unsigned awidth(input int unsigned chw, input int unsigned qwidth,
                                           input int unsigned cwidth);
        return chw + qwidth + cwidth;
    endfunction

    // LSB of channel ch inside the flattened cell-count bus.
    function automatic int unsigned cnt_lsb(input int unsigned ch, input int unsigned qwidth);
        return ch * (qwidth + 1);
    endfunction

endpackage

// File: rtl/Simple_dual_port_RAM.sv
// Simple dual-port RAM: one write port, one registered read port, optional output register.
module Simple_dual_port_RAM #(
    parameter string       VENDOR   = "ALTERA",
    parameter string       RAM_TYPE = "MRAM",
    parameter int unsigned DWIDTH   = 8,
    parameter int unsigned AWIDTH   = 8,
    parameter int unsigned REG_OUT  = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wen_i,
    input  logic [AWIDTH-1:0] waddr_i,
    input  logic [DWIDTH-1:0] wdata_i,
    input  logic              ren_i,
    input  logic [AWIDTH-1:0] raddr_i,
    output logic [DWIDTH-1:0] rdata_o
);

    // Vendor/style only steer inference on the target tool; behaviour is identical.
    localparam bit unused_ram_style = (VENDOR == "ALTERA") && (RAM_TYPE == "MRAM");

    logic [DWIDTH-1:0] mem_q [2**AWIDTH];
    logic [DWIDTH-1:0] rd_q;

    always_ff @(posedge clk_i) begin
        if (wen_i) mem_q[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)    rd_q <= '0;
        else if (ren_i) rd_q <= mem_q[raddr_i];
    end

    if (REG_OUT != 0) begin : g_reg_out
        logic [DWIDTH-1:0] out_q;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) out_q <= '0;
            else         out_q <= rd_q;
        end
        assign rdata_o = out_q;
    end else begin : g_no_reg_out
        assign rdata_o = rd_q;
    end

endmodule

// File: rtl/sync_mq_cell_ctrl.sv
// One channel of the cell FIFO: pointers, committed-cell count, flags and reject pulses.
module sync_mq_cell_ctrl #(
    parameter int unsigned QWIDTH     = 2,
    parameter int unsigned ALFULL_TH  = 1,
    parameter int unsigned ALEMPTY_TH = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wsel_i,
    input  logic              weoc_i,
    input  logic              rsel_i,
    input  logic              reoc_i,
    output logic              wr_ok_o,
    output logic              rd_ok_o,
    output logic [QWIDTH-1:0] wptr_o,
    output logic [QWIDTH-1:0] rptr_o,
    output logic [QWIDTH:0]   cnt_o,
    output logic              full_o,
    output logic              alfull_o,
    output logic              empty_o,
    output logic              alempty_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam logic [QWIDTH:0] CntMax  = {1'b1, {QWIDTH{1'b0}}};
    localparam int unsigned     AfLevel = (1 << QWIDTH) - ALFULL_TH;

    logic [QWIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [QWIDTH:0]   cnt_q, cnt_d;
    logic              ovf_q, udf_q;
    logic              inc, dec;

    assign full_o    = (cnt_q == CntMax);
    assign empty_o   = (cnt_q == '0);
    assign alfull_o  = (32'(cnt_q) >= AfLevel);
    assign alempty_o = (32'(cnt_q) <= ALEMPTY_TH);

    // Acceptance is decided on the flags as they stood at the start of the cycle.
    assign wr_ok_o = wsel_i && !full_o;
    assign rd_ok_o = rsel_i && !empty_o;
    assign inc     = wr_ok_o && weoc_i;
    assign dec     = rd_ok_o && reoc_i;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (inc) wptr_d = wptr_q + QWIDTH'(1);
        if (dec) rptr_d = rptr_q + QWIDTH'(1);
        if (inc && !dec)      cnt_d = cnt_q + (QWIDTH+1)'(1);
        else if (dec && !inc) cnt_d = cnt_q - (QWIDTH+1)'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            ovf_q  <= wsel_i && full_o;
            udf_q  <= rsel_i && empty_o;
        end
    end

    assign wptr_o      = wptr_q;
    assign rptr_o      = rptr_q;
    assign cnt_o       = cnt_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = udf_q;

endmodule

// File: rtl/sync_mq_cell_fifo.sv
// Multi-queue cell FIFO: NCH cell queues statically partitioned over one simple-dual-port RAM.
module sync_mq_cell_fifo
    import sync_mq_cell_fifo_pkg::*;
#(
    parameter string       VENDOR     = "ALTERA",
    parameter string       RAM_TYPE   = "MRAM",
    parameter int unsigned DWIDTH     = 8,
    parameter int unsigned CWIDTH     = 2,
    parameter int unsigned QWIDTH     = 2,
    parameter int unsigned CHW        = 2,
    parameter int unsigned ALFULL_TH  = 1,
    parameter int unsigned ALEMPTY_TH = 1,
    parameter int unsigned REG_OUT    = 0
) (
    input  logic                              i_clk_sys,
    input  logic                              i_rst_n,
    input  logic                              i_wen,
    input  logic                              i_weoc,
    input  logic [CHW-1:0]                    i_wch,
    input  logic [CWIDTH-1:0]                 i_waddr,
    input  logic [DWIDTH-1:0]                 i_wdata,
    input  logic                              i_ren,
    input  logic                              i_reoc,
    input  logic [CHW-1:0]                    i_rch,
    input  logic [CWIDTH-1:0]                 i_raddr,
    output logic [DWIDTH-1:0]                 o_rdata,
    output logic                              o_rvalid,
    output logic [CHW-1:0]                    o_rch,
    output logic [2**CHW-1:0]                 o_full,
    output logic [2**CHW-1:0]                 o_alfull,
    output logic [2**CHW-1:0]                 o_empty,
    output logic [2**CHW-1:0]                 o_alempty,
    output logic [2**CHW-1:0]                 o_overflow,
    output logic [2**CHW-1:0]                 o_underflow,
    output logic [(2**CHW)*(QWIDTH+1)-1:0]    o_cell_cnt
);

    localparam int unsigned NCH    = nch(CHW);
    localparam int unsigned CNTW   = cntw(QWIDTH);
    localparam int unsigned AWIDTH = awidth(CHW, QWIDTH, CWIDTH);
    localparam int unsigned LAT    = (REG_OUT != 0) ? 2 : 1;

    logic [NCH-1:0]    wsel, rsel, wr_ok, rd_ok;
    logic [QWIDTH-1:0] wptr [NCH];
    logic [QWIDTH-1:0] rptr [NCH];
    logic [CNTW-1:0]   cnt  [NCH];

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign wsel[c] = i_wen && (i_wch == CHW'(c));
        assign rsel[c] = i_ren && (i_rch == CHW'(c));

        sync_mq_cell_ctrl #(
            .QWIDTH     (QWIDTH),
            .ALFULL_TH  (ALFULL_TH),
            .ALEMPTY_TH (ALEMPTY_TH)
        ) u_ctrl (
            .clk_i       (i_clk_sys),
            .rst_ni      (i_rst_n),
            .wsel_i      (wsel[c]),
            .weoc_i      (i_weoc),
            .rsel_i      (rsel[c]),
            .reoc_i      (i_reoc),
            .wr_ok_o     (wr_ok[c]),
            .rd_ok_o     (rd_ok[c]),
            .wptr_o      (wptr[c]),
            .rptr_o      (rptr[c]),
            .cnt_o       (cnt[c]),
            .full_o      (o_full[c]),
            .alfull_o    (o_alfull[c]),
            .empty_o     (o_empty[c]),
            .alempty_o   (o_alempty[c]),
            .overflow_o  (o_overflow[c]),
            .underflow_o (o_underflow[c])
        );

        assign o_cell_cnt[cnt_lsb(c, QWIDTH) +: CNTW] = cnt[c];
    end

    logic              ram_wen, ram_ren;
    logic [AWIDTH-1:0] ram_waddr, ram_raddr;

    // The open write cell and the committed read cell never share a pointer value.
    assign ram_wen   = wr_ok[i_wch];
    assign ram_ren   = rd_ok[i_rch];
    assign ram_waddr = {i_wch, wptr[i_wch], i_waddr};
    assign ram_raddr = {i_rch, rptr[i_rch], i_raddr};

    Simple_dual_port_RAM #(
        .VENDOR   (VENDOR),
        .RAM_TYPE (RAM_TYPE),
        .DWIDTH   (DWIDTH),
        .AWIDTH   (AWIDTH),
        .REG_OUT  (REG_OUT)
    ) u_ram (
        .clk_i   (i_clk_sys),
        .rst_ni  (i_rst_n),
        .wen_i   (ram_wen),
        .waddr_i (ram_waddr),
        .wdata_i (i_wdata),
        .ren_i   (ram_ren),
        .raddr_i (ram_raddr),
        .rdata_o (o_rdata)
    );

    logic [LAT-1:0] vld_q;
    logic [CHW-1:0] ch_q [LAT];

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_q[0] <= 1'b0;
            ch_q[0]  <= '0;
        end else begin
            vld_q[0] <= ram_ren;
            ch_q[0]  <= i_rch;
        end
    end

    if (LAT > 1) begin : g_lat2
        always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
            if (!i_rst_n) begin
                vld_q[1] <= 1'b0;
                ch_q[1]  <= '0;
            end else begin
                vld_q[1] <= vld_q[0];
                ch_q[1]  <= ch_q[0];
            end
        end
    end

    assign o_rvalid = vld_q[LAT-1];
    assign o_rch    = ch_q[LAT-1];

endmodule
